// File: rtl/mul_add_16bit_seq.sv
// -----------------------------------------------------------------------------
// mul_add_16bit_seq
//
// Sequential shift-add multiply-accumulate: p = q*d + r (all unsigned).
// This block is the inverse of the 16-bit divider. Given quotient, divisor and
// remainder, it rebuilds the dividend. It is also used as a standalone MAC.
// It runs one shift-add iteration per clock, always exactly WIDTH iterations.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        operands valid
//   in_ready   out  1        block can accept operands (IDLE only)
//   q          in   WIDTH    multiplier (quotient)
//   d          in   WIDTH    multiplicand (divisor)
//   r          in   WIDTH    addend (remainder), zero-extended
//   out_valid  out  1        result valid (DONE only)
//   out_ready  in   1        downstream accepts result
//   p          out  2*WIDTH  registered result q*d + r
// -----------------------------------------------------------------------------
module mul_add_16bit_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   q,
    input  logic [WIDTH-1:0]   d,
    input  logic [WIDTH-1:0]   r,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      mcand;
    logic [WIDTH-1:0]   mplr;
    logic [CNT_W-1:0]   cnt;
    logic [PW-1:0]      acc_next;

    // One shift-add step. The addition never overflows, because the largest
    // possible final value, (2^W-1)^2 + (2^W-1), still fits in 2*WIDTH bits.
    function automatic logic [PW-1:0] shift_add_step(
        input logic [PW-1:0] acc_in,
        input logic [PW-1:0] mcand_in,
        input logic          bit_in
    );
        shift_add_step = bit_in ? (acc_in + mcand_in) : acc_in;
    endfunction

    assign acc_next = shift_add_step(acc, mcand, mplr[0]);

    // in_ready/out_valid are registered next to the state, so each one is a
    // pure function of the current state. p is loaded only when the
    // computation finishes, so it holds its value until the next DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            p         <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc      <= {{WIDTH{1'b0}}, r};
                        mcand    <= {{WIDTH{1'b0}}, d};
                        mplr     <= q;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                    // The WIDTH-th iteration happens on this edge. The
                    // result goes straight to p, with no extra cycle.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        p         <= acc_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
